cache_flush_ctrl: RTL and testbench
===================================

Name: cache_flush_ctrl

Overview:
Sequencer that drives the index/load side of the cache's per-set state arrays (valid and dirty bit arrays, one 1-bit array per way) and reads their combinational outputs. On a flush request it walks every set, writes back each valid+dirty line through a request/ack handshake to the memory-side arbiter, clears the dirty bits, and optionally invalidates every set. It sits beside the main cache controller, which hands the array control ports to it while flush_busy is high.

Parameters:
s_index, 3, set index width; num_sets = 2**s_index
ways, 2, number of ways; each way has its own valid array and dirty array

Ports:
clk  input  1  clock
rst  input  1  reset
flush_req  input  1  start flush; sampled only in IDLE
flush_inv  input  1  invalidate all sets during this flush; latched with flush_req
flush_busy  output  1  high from the cycle after acceptance through the DONE cycle
flush_done  output  1  one-cycle pulse at completion
arr_rindex  output  s_index  read index to valid/dirty arrays
arr_windex  output  s_index  write index to valid/dirty arrays
valid_rdata  input  ways  valid bits at arr_rindex, combinational, same cycle
dirty_rdata  input  ways  dirty bits at arr_rindex, combinational, same cycle
valid_load  output  ways  per-way valid array write enable
dirty_load  output  ways  per-way dirty array write enable
arr_wdata  output  1  write data to arrays; constant 0
wb_req  output  1  write-back request to memory side
wb_index  output  s_index  set of line being written back
wb_way  output  clog2(ways), min 1  way of line being written back
wb_ack  input  1  write-back complete

Behaviour:
- Reset: rst is synchronous, active-high; clock clk. All outputs 0, state IDLE, idx 0, inv latch 0. rst mid-flush abandons the operation (including an outstanding wb_req) with no further array writes; wb_ack after reset is ignored.
- Arrays: reads combinational; writes take effect at the next clk edge. arr_rindex = arr_windex = idx in every state.
- States: IDLE, SCAN, WB, DONE.
- IDLE: flush_req=1 -> latch flush_inv, idx<=0, go SCAN. flush_req while not IDLE is ignored (no queueing).
- SCAN: pend = valid_rdata & dirty_rdata. pend != 0 -> w = lowest set bit, latch w, go WB; no array writes this cycle. pend == 0 -> if inv latched, valid_load = all ones (wdata 0) this cycle; then idx == num_sets-1 -> DONE, else idx++ and stay SCAN.
- WB: wb_req=1, wb_index=idx, wb_way=w, held stable until wb_ack is sampled high. wb_ack may be high in the first WB cycle. In the ack cycle: wb_req still high, dirty_load[w]=1; next state SCAN at same idx, so remaining dirty ways of that set are handled in ascending way order.
- Dirty but invalid lines are not written back, and their dirty bits are not cleared.
- DONE: flush_done=1, flush_busy=1 for this single cycle; then IDLE and busy=0.
- Latency (flush_req sampled at cycle 0, clean cache): SCAN cycles 1..num_sets, done pulse at cycle num_sets+1. Each dirty line adds (WB cycles up to and including ack) + 1 re-scan cycle.
- wb_ack outside WB is ignored. Only one load bit is asserted per way per cycle. valid_load and dirty_load are never asserted in the same cycle.

Optional Feature:
FLUSH_STATS_EN: when defined, adds output wb_count [s_index+clog2(ways):0]. It is cleared to 0 when a flush is accepted, increments on each wb_ack handshake, holds after DONE, and resets to 0. When undefined, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- s_index=3, ways=2, all lines clean, flush_inv=0, flush_req at cycle 0 -> no wb_req, no loads, flush_done for exactly one cycle at cycle 9, busy high cycles 1-9.
- Set 5 way1 valid+dirty, wb_ack 3 cycles after wb_req rises -> wb_req with index 5, way 1 held 4 cycles; dirty_load=2'b10 with windex 5 in the ack cycle; set 5 rescanned; done at cycle 9+5.
- Set 2 both ways valid+dirty, ack immediate -> two write-backs (way 0, then way 1), each followed by a re-scan; both dirty bits end at 0.
- flush_inv=1, set 0 way0 dirty -> write-back first; then valid_load=2'b11 at indices 0..7; all valid bits 0 afterwards.
- Set 3 way0 dirty but invalid; flush_req pulsed again mid-flush -> no write-back, dirty bit stays 1, second request ignored, single done pulse.
- rst during WB wait -> next cycle all outputs 0 and IDLE; a later stray wb_ack is ignored; a new flush then completes normally (wb_count reads 0 after reset when FLUSH_STATS_EN is defined).

Source files
------------

// File: rtl/cache_flush_ctrl.sv
// -----------------------------------------------------------------------------
// cache_flush_ctrl
//
// Flush sequencer for a set-associative cache. While flush_busy is high it owns
// the index/load ports of the per-way valid and dirty bit arrays. It walks every
// set, writes back each valid+dirty line through wb_req/wb_ack, clears the dirty
// bit of each written-back line, and can optionally invalidate every set.
//
// Parameters:
//   s_index : set index width, num_sets = 2**s_index
//   ways    : number of ways (one valid array and one dirty array per way)
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush_req     : start a flush (only looked at while idle)
//   flush_inv     : invalidate all sets during this flush (latched with flush_req)
//   flush_busy    : high from the cycle after acceptance through the done cycle
//   flush_done    : one-cycle completion pulse
//   arr_rindex    : array read index (arrays answer combinationally)
//   arr_windex    : array write index (writes land on the next clk edge)
//   valid_rdata   : per-way valid bits at arr_rindex
//   dirty_rdata   : per-way dirty bits at arr_rindex
//   valid_load    : per-way valid array write enable
//   dirty_load    : per-way dirty array write enable
//   arr_wdata     : array write data, always 0
//   wb_req        : write-back request to the memory-side arbiter
//   wb_index      : set of the line being written back
//   wb_way        : way of the line being written back
//   wb_ack        : write-back complete
//   wb_count      : write-backs in the current/last flush (FLUSH_STATS_EN only)
//   dbg_state     : current FSM state (0 IDLE, 1 SCAN, 2 WB, 3 DONE)
//
// Optional feature: define FLUSH_STATS_EN to add the wb_count output.
//
// Write-back handshake: wb_req rises with wb_index/wb_way and all three stay
// stable until the first cycle in which wb_ack is sampled high (which may be the
// very first wb_req cycle). That cycle completes the transfer; wb_req drops on
// the following edge. wb_ack while wb_req is low has no effect.
// -----------------------------------------------------------------------------
module cache_flush_ctrl #(
  parameter int s_index = 3,
  parameter int ways    = 2,
  localparam int num_sets = 2 ** s_index,
  localparam int way_w    = (ways > 1) ? $clog2(ways) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_req,
  input  logic                   flush_inv,
  output logic                   flush_busy,
  output logic                   flush_done,
  output logic [s_index-1:0]     arr_rindex,
  output logic [s_index-1:0]     arr_windex,
  input  logic [ways-1:0]        valid_rdata,
  input  logic [ways-1:0]        dirty_rdata,
  output logic [ways-1:0]        valid_load,
  output logic [ways-1:0]        dirty_load,
  output logic                   arr_wdata,
  output logic                   wb_req,
  output logic [s_index-1:0]     wb_index,
  output logic [way_w-1:0]       wb_way,
  input  logic                   wb_ack,
`ifdef FLUSH_STATS_EN
  output logic [s_index+way_w:0] wb_count,
`endif
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [s_index-1:0] last_idx = s_index'(num_sets - 1);

  state_t             state;
  logic [s_index-1:0] idx;
  logic [way_w-1:0]   way_q;
  logic               inv_q;

  logic [ways-1:0]    pend;
  logic [way_w-1:0]   low_way;

  // Lines needing write-back in the set currently addressed; the lowest way
  // wins so a set's dirty ways are drained in ascending order across re-scans.
  always_comb begin
    pend    = valid_rdata & dirty_rdata;
    low_way = '0;
    for (int i = ways - 1; i >= 0; i--) begin
      if (pend[i]) low_way = way_w'(i);
    end
  end

  // Array writes depend on same-cycle array reads and on wb_ack, so the load
  // strobes are combinational. They are forced low during reset so an
  // abandoned flush never touches the arrays.
  always_comb begin
    valid_load = '0;
    dirty_load = '0;
    if (!rst) begin
      if (state == SCAN && pend == '0 && inv_q) valid_load = '1;
      if (state == WB && wb_ack) dirty_load = ways'(1) << way_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      way_q      <= '0;
      inv_q      <= 1'b0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
      wb_req     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_req) begin
            inv_q      <= flush_inv;
            idx        <= '0;
            flush_busy <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (pend != '0) begin
            way_q  <= low_way;
            wb_req <= 1'b1;
            state  <= WB;
          end else if (idx == last_idx) begin
            flush_done <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx + s_index'(1);
          end
        end
        WB: begin
          // Return to SCAN at the same index to pick up further dirty ways.
          if (wb_ack) begin
            wb_req <= 1'b0;
            state  <= SCAN;
          end
        end
        DONE: begin
          flush_done <= 1'b0;
          flush_busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FLUSH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_count <= '0;
    end else if (state == IDLE && flush_req) begin
      wb_count <= '0;
    end else if (state == WB && wb_ack) begin
      wb_count <= wb_count + (s_index + way_w + 1)'(1);
    end
  end
`endif

  assign arr_rindex = idx;
  assign arr_windex = idx;
  assign wb_index   = idx;
  assign wb_way     = way_q;
  assign arr_wdata  = 1'b0;
  assign dbg_state  = state;

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_flush_ctrl
//
// Bench for cache_flush_ctrl (s_index=3, ways=2). The valid/dirty arrays are
// modelled here as plain memories. Before each flush the expected outcome is
// computed from the array contents: the ordered list of write-backs (set
// ascending, way ascending, valid&dirty only), the cycle of the done pulse
// (num_sets+1 plus, per write-back, ack delay + 1 WB cycles and 1 re-scan),
// and the final array contents.
// -----------------------------------------------------------------------------
module tb_cache_flush_ctrl;

  localparam int S_INDEX  = 3;
  localparam int WAYS     = 2;
  localparam int NUM_SETS = 8;
  localparam int WAY_W    = 1;
  localparam int EW       = S_INDEX + WAY_W;

  logic               clk;
  logic               rst;
  logic               flush_req;
  logic               flush_inv;
  logic               flush_busy;
  logic               flush_done;
  logic [S_INDEX-1:0] arr_rindex;
  logic [S_INDEX-1:0] arr_windex;
  logic [WAYS-1:0]    valid_rdata;
  logic [WAYS-1:0]    dirty_rdata;
  logic [WAYS-1:0]    valid_load;
  logic [WAYS-1:0]    dirty_load;
  logic               arr_wdata;
  logic               wb_req;
  logic [S_INDEX-1:0] wb_index;
  logic [WAY_W-1:0]   wb_way;
  logic               wb_ack;
  logic [1:0]         dbg_state;
`ifdef FLUSH_STATS_EN
  logic [S_INDEX+WAY_W:0] wb_count;
`endif

  int n_pass  = 0;
  int n_total = 0;

  cache_flush_ctrl #(.s_index(S_INDEX), .ways(WAYS)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_req   (flush_req),
    .flush_inv   (flush_inv),
    .flush_busy  (flush_busy),
    .flush_done  (flush_done),
    .arr_rindex  (arr_rindex),
    .arr_windex  (arr_windex),
    .valid_rdata (valid_rdata),
    .dirty_rdata (dirty_rdata),
    .valid_load  (valid_load),
    .dirty_load  (dirty_load),
    .arr_wdata   (arr_wdata),
    .wb_req      (wb_req),
    .wb_index    (wb_index),
    .wb_way      (wb_way),
    .wb_ack      (wb_ack),
`ifdef FLUSH_STATS_EN
    .wb_count    (wb_count),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- array memories ----------------
  logic [WAYS-1:0] valid_arr [NUM_SETS];
  logic [WAYS-1:0] dirty_arr [NUM_SETS];
  logic [WAYS-1:0] pre_v [NUM_SETS];
  logic [WAYS-1:0] pre_d [NUM_SETS];
  logic            pre_load;

  assign valid_rdata = valid_arr[arr_rindex];
  assign dirty_rdata = dirty_arr[arr_rindex];

  always @(posedge clk) begin
    if (pre_load) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_arr[s] <= pre_v[s];
        dirty_arr[s] <= pre_d[s];
      end
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        if (valid_load[w]) valid_arr[arr_windex][w] <= arr_wdata;
        if (dirty_load[w]) dirty_arr[arr_windex][w] <= arr_wdata;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pre_clear();
    for (int s = 0; s < NUM_SETS; s++) begin
      pre_v[s] = '0;
      pre_d[s] = '0;
    end
  endtask

  task automatic pre_apply();
    pre_load = 1'b1;
    tick();
    pre_load = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},   flush_busy, 0);
    chk({tag, "_done"},   flush_done, 0);
    chk({tag, "_wbreq"},  wb_req,     0);
    chk({tag, "_vload"},  valid_load, 0);
    chk({tag, "_dload"},  dirty_load, 0);
    chk({tag, "_state"},  dbg_state,  0);
  endtask

  // Run one complete flush against the current array contents.
  // fixed_d < 0 picks a random ack delay (0..3) per write-back.
  // mid_req > 0 pulses flush_req again in that busy cycle.
  task automatic run_flush(input logic inv, input int fixed_d, input int mid_req);
    logic [EW-1:0]   exp_q[$];
    int              dly_q[$];
    logic [WAYS-1:0] exp_v [NUM_SETS];
    logic [WAYS-1:0] exp_d [NUM_SETS];
    int exp_done, exp_n, next_inv, wcnt, cur_d, d;
    logic in_wb;

    // scoreboard: expected write-backs, timing and final arrays
    exp_done = NUM_SETS + 1;
    for (int s = 0; s < NUM_SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (valid_arr[s][w] && dirty_arr[s][w]) begin
          exp_q.push_back({S_INDEX'(s), WAY_W'(w)});
          d = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 3));
          dly_q.push_back(d);
          exp_done += d + 2;
        end
      end
      exp_v[s] = inv ? '0 : valid_arr[s];
      exp_d[s] = dirty_arr[s] & ~valid_arr[s];
    end
    exp_n    = exp_q.size();
    next_inv = 0;
    in_wb    = 1'b0;
    wcnt     = 0;
    cur_d    = 0;

    flush_req = 1'b1;
    flush_inv = inv;
    wb_ack    = 1'b0;
    tick();

    for (int cyc = 1; cyc <= exp_done; cyc++) begin
      flush_req = (cyc == mid_req);
      flush_inv = ~inv;
      if (wb_req === 1'b1) begin
        if (!in_wb) begin
          in_wb = 1'b1;
          wcnt  = 0;
          cur_d = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
        end
        wb_ack = (wcnt == cur_d);
      end else begin
        in_wb  = 1'b0;
        wb_ack = 1'($urandom_range(0, 1));
      end
      #1;
      chk("busy", flush_busy, 1);
      chk("done_pulse", flush_done, (cyc == exp_done));
      chk("wdata", arr_wdata, 0);
      chk("load_excl", ((|valid_load) && (|dirty_load)), 0);
      chk("rw_index", (arr_rindex == arr_windex), 1);
      if (wb_req === 1'b1) begin
        chk("wb_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("wb_index", wb_index, exp_q[0][EW-1:WAY_W]);
          chk("wb_way", wb_way, exp_q[0][WAY_W-1:0]);
          if (wb_ack) begin
            chk("wb_dload", dirty_load, WAYS'(1) << exp_q[0][WAY_W-1:0]);
            chk("wb_windex", arr_windex, exp_q[0][EW-1:WAY_W]);
            void'(exp_q.pop_front());
            in_wb = 1'b0;
          end else begin
            chk("wb_wait_dload", dirty_load, 0);
          end
        end
      end else begin
        chk("dload_idle", dirty_load, 0);
      end
      if (|valid_load) begin
        chk("vload_inv", inv, 1);
        chk("vload_all", valid_load, {WAYS{1'b1}});
        chk("vload_index", arr_windex, next_inv);
        chk("vload_after_wb", (exp_q.size() == 0 || exp_q[0][EW-1:WAY_W] > arr_windex), 1);
        next_inv++;
      end
      wcnt++;
      tick();
    end

    flush_req = 1'b0;
    wb_ack    = 1'b0;
    #1;
    chk_idle_outputs("post");
    tick();
    chk("post2_busy", flush_busy, 0);
    chk("inv_count", next_inv, inv ? NUM_SETS : 0);
    chk("wb_left", exp_q.size(), 0);
    for (int s = 0; s < NUM_SETS; s++) begin
      chk($sformatf("valid_s%0d", s), valid_arr[s], exp_v[s]);
      chk($sformatf("dirty_s%0d", s), dirty_arr[s], exp_d[s]);
    end
`ifdef FLUSH_STATS_EN
    chk("wb_count", wb_count, exp_n);
`else
    if (exp_n < 0) chk("wb_count_n", exp_n, 0);
`endif
  endtask

  // ---------------- directed + random sequence ----------------
  logic seen;
  int   mid;

  initial begin
    rst       = 1'b1;
    flush_req = 1'b0;
    flush_inv = 1'b0;
    wb_ack    = 1'b0;
    pre_load  = 1'b0;
    pre_clear();
    pre_apply();
    tick();
    chk_idle_outputs("reset");
    chk("reset_rindex", arr_rindex, 0);
    chk("reset_wbway", wb_way, 0);
`ifdef FLUSH_STATS_EN
    chk("reset_wb_count", wb_count, 0);
`endif
    rst = 1'b0;
    tick();

    // clean cache: done at cycle 9, no write-backs
    pre_clear();
    pre_apply();
    run_flush(1'b0, -1, 0);

    // set 5 way 1 dirty, ack three cycles after request: done at 14
    pre_clear();
    pre_v[5] = 2'b10;
    pre_d[5] = 2'b10;
    pre_apply();
    run_flush(1'b0, 3, 0);

    // set 2 both ways dirty, immediate ack
    pre_clear();
    pre_v[2] = 2'b11;
    pre_d[2] = 2'b11;
    pre_v[6] = 2'b01;
    pre_apply();
    run_flush(1'b0, 0, 0);

    // invalidate flush with a write-back in set 0
    pre_clear();
    for (int s = 0; s < NUM_SETS; s++) pre_v[s] = WAYS'($urandom_range(0, 3));
    pre_v[0] = 2'b01;
    pre_d[0] = 2'b01;
    pre_apply();
    run_flush(1'b1, -1, 0);

    // dirty but invalid line, extra request mid-flush
    pre_clear();
    pre_v[3] = 2'b00;
    pre_d[3] = 2'b01;
    pre_v[1] = 2'b11;
    pre_apply();
    run_flush(1'b0, -1, 4);

    // reset while waiting for wb_ack
    pre_clear();
    pre_v[4] = 2'b01;
    pre_d[4] = 2'b01;
    pre_apply();
    flush_req = 1'b1;
    flush_inv = 1'b0;
    wb_ack    = 1'b0;
    tick();
    flush_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (wb_req === 1'b1) seen = 1'b1;
      else tick();
    end
    chk("rst_wb_seen", seen, 1);
    tick();
    tick();
    rst    = 1'b1;
    wb_ack = 1'b1;
    #1;
    chk("rst_cycle_vload", valid_load, 0);
    chk("rst_cycle_dload", dirty_load, 0);
    tick();
    rst = 1'b0;
    #1;
    chk_idle_outputs("after_rst");
    chk("after_rst_windex", arr_windex, 0);
    chk("after_rst_wbindex", wb_index, 0);
    chk("after_rst_wbway", wb_way, 0);
`ifdef FLUSH_STATS_EN
    chk("after_rst_wb_count", wb_count, 0);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray_ack_busy", flush_busy, 0);
      chk("stray_ack_dload", dirty_load, 0);
    end
    wb_ack = 1'b0;
    chk("rst_dirty_kept", dirty_arr[4], 2'b01);
    run_flush(1'b0, 1, 0);

    // random array contents, random invalidate, random ack delays
    for (int r = 0; r < 10; r++) begin
      pre_clear();
      for (int s = 0; s < NUM_SETS; s++) begin
        pre_v[s] = WAYS'($urandom_range(0, 3));
        pre_d[s] = WAYS'($urandom_range(0, 3));
      end
      pre_apply();
      mid = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 9)) : 0;
      run_flush(1'($urandom_range(0, 1)), -1, mid);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
